// File: rtl/dispatch_queue_mw_if.sv
// dispatch_queue_mw_if: decode/issue side bundle for the multi-wide dispatch queue.
//
// Signals (named from the queue's point of view in modport slave):
//   flush        in   synchronous clear of all queued entries
//   enq_valid    in   per-lane enqueue request, thermometer coded
//   enq_instr    in   lane i at [i*INSTR_W +: INSTR_W]
//   enq_ready    out  all ENQ_W lanes may enqueue this cycle
//   deq_valid    out  thermometer, lane i valid iff count > i
//   deq_instr    out  lane i = entry at head+i (oldest in lane 0)
//   deq_cnt      in   number of head entries consumed this cycle
//   count        out  current occupancy
//   empty/full   out  occupancy status
//   almost_full  out  free entries below the watermark
// The master modport is the decode/issue side (or a testbench).

`ifndef DE_instr_width
`define DE_instr_width 32
`endif

interface dispatch_queue_mw_if #(
  parameter int unsigned INSTR_W = `DE_instr_width,
  parameter int unsigned ENQ_W   = 2,
  parameter int unsigned DEQ_W   = 2,
  parameter int unsigned DEPTH   = 128
);

  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned DeqCntW = $clog2(DEQ_W + 1);

  logic                       flush;
  logic [ENQ_W-1:0]           enq_valid;
  logic [ENQ_W*INSTR_W-1:0]   enq_instr;
  logic                       enq_ready;
  logic [DEQ_W-1:0]           deq_valid;
  logic [DEQ_W*INSTR_W-1:0]   deq_instr;
  logic [DeqCntW-1:0]         deq_cnt;
  logic [CntW-1:0]            count;
  logic                       empty;
  logic                       full;
  logic                       almost_full;

  modport master (
    output flush, enq_valid, enq_instr, deq_cnt,
    input  enq_ready, deq_valid, deq_instr, count, empty, full, almost_full
  );

  modport slave (
    input  flush, enq_valid, enq_instr, deq_cnt,
    output enq_ready, deq_valid, deq_instr, count, empty, full, almost_full
  );

endinterface

// File: rtl/dispatch_queue_mw.sv
// dispatch_queue_mw: multi-wide in-order dispatch queue between decode and issue.
//
// Accepts up to ENQ_W instructions per cycle and presents the DEQ_W oldest entries
// fall-through (zero latency) to issue. Occupancy is tracked with wrap-bit pointers,
// so full and empty are told apart by the pointer MSB.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset; clears pointers, not the array
//   bus    slave modport of dispatch_queue_mw_if (enqueue, dequeue, status, flush)
//
// All status outputs come from the registered pointers only; enq_ready does not see
// same-cycle dequeues. Interface parameters must match this module's parameters.

`ifndef DE_instr_width
`define DE_instr_width 32
`endif

module dispatch_queue_mw #(
  parameter int unsigned INSTR_W  = `DE_instr_width,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ENQ_W    = 2,
  parameter int unsigned DEQ_W    = 2,
  parameter int unsigned AFULL_TH = 8
) (
  input logic                clk,
  input logic                rst_n,
  dispatch_queue_mw_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned MaxW = (ENQ_W > DEQ_W) ? ENQ_W : DEQ_W;

  // Elaboration-time parameter checks.
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
    $error("dispatch_queue_mw: DEPTH must be a power of 2");
  end
  if (DEPTH < 2 * MaxW) begin : g_bad_depth_size
    $error("dispatch_queue_mw: DEPTH must be at least 2*max(ENQ_W,DEQ_W)");
  end
  if (ENQ_W < 1 || ENQ_W > 4) begin : g_bad_enq_w
    $error("dispatch_queue_mw: ENQ_W must be 1..4");
  end
  if (DEQ_W < 1 || DEQ_W > 4) begin : g_bad_deq_w
    $error("dispatch_queue_mw: DEQ_W must be 1..4");
  end

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      count;
  logic [PW-1:0]      free;
  logic [PW-1:0]      n_enq;
  logic [PW-1:0]      acc_enq;
  logic [PW-1:0]      n_pop;
  logic               enq_ready;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_idx [ENQ_W];
  logic [AW-1:0]      rd_idx [DEQ_W];

  // Occupancy from the wrap-bit pointers; subtraction is modulo 2^PW.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign free      = PW'(DEPTH) - count;
  assign enq_ready = 32'(free) >= ENQ_W;

  // Lane count from the thermometer request.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      n_enq = n_enq + PW'(bus.enq_valid[i]);
    end
  end

  assign acc_enq = enq_ready ? n_enq : '0;

  // Requests beyond the valid head entries are clipped.
  assign n_pop = (32'(bus.deq_cnt) > 32'(count)) ? count : PW'(bus.deq_cnt);

  always_comb begin
    wr_ptr_d = wr_ptr_q + acc_enq;
    rd_ptr_d = rd_ptr_q + n_pop;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Per-lane write addresses; the AW-bit sum wraps past the array end naturally.
  for (genvar g = 0; g < ENQ_W; g++) begin : g_wr_lane
    assign wr_idx[g] = wr_ptr_q[AW-1:0] + AW'(g);
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (enq_ready && !bus.flush) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (PW'(i) < n_enq) begin
          mem_q[wr_idx[i]] <= bus.enq_instr[i*INSTR_W +: INSTR_W];
        end
      end
    end
  end

  // Fall-through read lanes, oldest entry in lane 0.
  for (genvar g = 0; g < DEQ_W; g++) begin : g_rd_lane
    assign rd_idx[g]                          = rd_ptr_q[AW-1:0] + AW'(g);
    assign bus.deq_instr[g*INSTR_W +: INSTR_W] = mem_q[rd_idx[g]];
    assign bus.deq_valid[g]                   = count > PW'(g);
  end

  assign bus.enq_ready   = enq_ready;
  assign bus.count       = count;
  assign bus.empty       = (count == '0);
  assign bus.full        = (count == PW'(DEPTH));
  assign bus.almost_full = 32'(free) < AFULL_TH;

endmodule

// File: tb/tb_dispatch_queue_mw.sv
// Bench for dispatch_queue_mw: directed vector table, reset/flush sequences, an
// ordered tag stream across the wrap, and random traffic, all scored against a
// queue-based reference model of the occupancy and ordering rules.

module tb_dispatch_queue_mw;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ENQ_W    = 2;
  localparam int unsigned DEQ_W    = 2;
  localparam int unsigned AFULL_TH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_queue_mw_if #(
    .INSTR_W(INSTR_W),
    .ENQ_W  (ENQ_W),
    .DEQ_W  (DEQ_W),
    .DEPTH  (DEPTH)
  ) bus ();

  dispatch_queue_mw #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ENQ_W   (ENQ_W),
    .DEQ_W   (DEQ_W),
    .AFULL_TH(AFULL_TH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int clips = 0;
  logic [INSTR_W-1:0] mq[$];

  typedef struct {
    logic               fl;
    logic [1:0]         ev;
    logic [INSTR_W-1:0] d0;
    logic [INSTR_W-1:0] d1;
    logic [1:0]         dc;
    int                 exp_cnt;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("count", 32'(bus.count), sz);
    chk("empty", 32'(bus.empty), 32'(sz == 0));
    chk("full", 32'(bus.full), 32'(sz == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'((DEPTH - sz) < AFULL_TH));
    chk("enq_ready", 32'(bus.enq_ready), 32'((DEPTH - sz) >= ENQ_W));
    chk("deq_valid", 32'(bus.deq_valid), {30'd0, sz > 1, sz > 0});
    if (sz > 0) chk("lane0_data", 32'(bus.deq_instr[15:0]), 32'(mq[0]));
    if (sz > 1) chk("lane1_data", 32'(bus.deq_instr[31:16]), 32'(mq[1]));
  endtask

  // One clock: drive, check at the falling edge, advance the model, settle past the edge.
  task automatic cycle(input logic fl, input logic [1:0] ev, input logic [INSTR_W-1:0] d0,
                       input logic [INSTR_W-1:0] d1, input logic [1:0] dc);
    int sz, pop, acc;
    assert (ev != 2'b10) else $error("non-thermometer enq_valid");
    bus.flush     = fl;
    bus.enq_valid = ev;
    bus.enq_instr = {d1, d0};
    bus.deq_cnt   = dc;
    @(negedge clk);
    check_outputs();
    sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      pop = (int'(dc) > sz) ? sz : int'(dc);
      if (int'(dc) > sz) clips++;
      acc = ((DEPTH - sz) >= ENQ_W) ? int'(ev[0]) + int'(ev[1]) : 0;
      for (int k = 0; k < pop; k++) void'(mq.pop_front());
      if (acc >= 1) mq.push_back(d0);
      if (acc == 2) mq.push_back(d1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int idx, input logic fl, input logic [1:0] ev,
                      input logic [INSTR_W-1:0] d0, input logic [INSTR_W-1:0] d1,
                      input logic [1:0] dc, input int exp_cnt);
    vecs[idx].fl      = fl;
    vecs[idx].ev      = ev;
    vecs[idx].d0      = d0;
    vecs[idx].d1      = d1;
    vecs[idx].dc      = dc;
    vecs[idx].exp_cnt = exp_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_tag;
    int n;
    bit done;
    logic [1:0] ev;

    // Fill 2/cycle to full, then a dropped push.
    for (int k = 0; k < 9; k++)
      setv(k, 1'b0, 2'b11, 16'(16'h0100 + 2 * k), 16'(16'h0101 + 2 * k), 2'd0,
           (k < 8) ? 2 * (k + 1) : 16);
    setv(9, 1'b0, 2'b00, 16'h0, 16'h0, 2'd1, 15);
    // count=15, both lanes requested while popping 2: enqueue blocked.
    setv(10, 1'b0, 2'b11, 16'h0BAD, 16'h0BAE, 2'd2, 13);
    for (int k = 0; k < 6; k++) setv(11 + k, 1'b0, 2'b00, 16'h0, 16'h0, 2'd2, 11 - 2 * k);
    // count=1, pop 2 is clipped to 1.
    setv(17, 1'b0, 2'b00, 16'h0, 16'h0, 2'd2, 0);
    setv(18, 1'b0, 2'b00, 16'h0, 16'h0, 2'd0, 0);
    for (int k = 0; k < 4; k++)
      setv(19 + k, 1'b0, 2'b11, 16'(16'h0200 + 2 * k), 16'(16'h0201 + 2 * k), 2'd0, 2 * (k + 1));
    setv(23, 1'b0, 2'b01, 16'h0208, 16'h0, 2'd0, 9);
    setv(24, 1'b1, 2'b11, 16'h0EEE, 16'h0EEF, 2'd1, 0);
    setv(25, 1'b0, 2'b01, 16'h000A, 16'h0, 2'd0, 1);
    setv(26, 1'b0, 2'b00, 16'h0, 16'h0, 2'd0, 1);
    setv(27, 1'b0, 2'b00, 16'h0, 16'h0, 2'd1, 0);

    bus.flush     = 1'b0;
    bus.enq_valid = '0;
    bus.enq_instr = '0;
    bus.deq_cnt   = '0;
    rst_n         = 1'b0;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_almost_full", 32'(bus.almost_full), 0);
    chk("rst_enq_ready", 32'(bus.enq_ready), 1);
    chk("rst_deq_valid", 32'(bus.deq_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      cycle(vecs[i].fl, vecs[i].ev, vecs[i].d0, vecs[i].d1, vecs[i].dc);
      chk($sformatf("vec%0d_count", i), 32'(bus.count), vecs[i].exp_cnt);
      if (i == 3) chk("afull_at_8", 32'(bus.almost_full), 0);
      if (i == 4) chk("afull_at_10", 32'(bus.almost_full), 1);
      if (i == 8) begin
        chk("full_at_16", 32'(bus.full), 1);
        chk("ready_at_16", 32'(bus.enq_ready), 0);
      end
      if (i == 17) chk("partial_empty", 32'(bus.empty), 1);
      if (i == 24) chk("flush_empty", 32'(bus.empty), 1);
      if (i == 25) begin
        chk("flush_push_lane0", 32'(bus.deq_instr[15:0]), 32'h000A);
        chk("flush_push_valid", 32'(bus.deq_valid), 32'b01);
      end
    end

    // Asynchronous reset with 5 entries queued.
    cycle(1'b0, 2'b11, 16'h0301, 16'h0302, 2'd0);
    cycle(1'b0, 2'b11, 16'h0303, 16'h0304, 2'd0);
    cycle(1'b0, 2'b01, 16'h0305, 16'h0, 2'd0);
    chk("pre_reset_count", 32'(bus.count), 5);
    bus.enq_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_empty", 32'(bus.empty), 1);
    chk("midrst_enq_ready", 32'(bus.enq_ready), 1);
    chk("midrst_deq_valid", 32'(bus.deq_valid), 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 2'd0);
    cycle(1'b0, 2'b00, 16'h0, 16'h0, 2'd1);

    // Ordered tags 0..39 across the wrap with random stalls.
    next_tag = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      n = $urandom_range(0, 2);
      if (n > 40 - next_tag) n = 40 - next_tag;
      ev = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      if ((DEPTH - mq.size()) >= ENQ_W) next_tag += n;
      else next_tag += 0;
      cycle(1'b0, ev, 16'(next_tag - ((DEPTH - mq.size()) >= ENQ_W ? n : 0)),
            16'(next_tag - ((DEPTH - mq.size()) >= ENQ_W ? n : 0) + 1),
            ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd2);
      done = (next_tag == 40) && (mq.size() == 0);
    end
    chk("order_stream_done", 32'(done), 1);

    // Random traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      n = $urandom_range(0, 2);
      ev = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      cycle(($urandom_range(0, 39) == 0), ev, 16'($urandom), 16'($urandom),
            2'($urandom_range(0, 2)));
    end

    $display("info: deq_cnt exceeded valid lanes %0d times (clipped)", clips);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
